// File: rtl/fp_to_cordic_stage_pkg.sv
// Shared stage package: widths, multiplier depth and FSM encodings
// for the float-to-CORDIC operand stage.
package fp_to_cordic_stage_pkg;

   localparam int FLOAT_W  = 32;
   localparam int INT_W    = 2;
   localparam int FRAC_W   = 20;
   localparam int CORDIC_W = INT_W + FRAC_W;
   localparam int MUL_LAT  = 3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_CONVERT  = 2'b01,
      S_MULTIPLY = 2'b10,
      S_DONE     = 2'b11
   } state_e;

endpackage

// File: rtl/fp_to_cordic_stage_fp_mul.sv
// Single-precision multiplier, round-to-nearest-even, denormals
// flushed to zero, followed by an enabled register pipeline.
module fp_mul #(
   parameter int STAGES = 2
) (
   input  logic        clk,
   input  logic        sclr,
   input  logic        clk_en,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);

   logic              sgn;
   logic [7:0]        ea, eb;
   logic [23:0]       ma, mb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [47:0]       prod;
   logic [22:0]       mant;
   logic              g, st, rb;
   logic [23:0]       rnd;
   logic signed [9:0] ex, ex2;
   logic [31:0]       res;

   always_comb begin
      sgn    = a_i[31] ^ b_i[31];
      ea     = a_i[30:23];
      eb     = b_i[30:23];
      ma     = {1'b1, a_i[22:0]};
      mb     = {1'b1, b_i[22:0]};
      a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
      a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      prod   = {24'b0, ma} * {24'b0, mb};
      if (prod[47]) begin
         mant = prod[46:24];
         g    = prod[23];
         st   = |prod[22:0];
      end else begin
         mant = prod[45:23];
         g    = prod[22];
         st   = |prod[21:0];
      end
      rb  = g & (st | mant[0]);
      rnd = {1'b0, mant} + {23'b0, rb};
      ex  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
          + $signed({9'b0, prod[47]});
      ex2 = ex + $signed({9'b0, rnd[23]});
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         res = 32'h7FC00000;
      else if (a_inf || b_inf)
         res = {sgn, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         res = {sgn, 31'd0};
      else if (ex2 >= 10'sd255)
         res = {sgn, 8'hFF, 23'd0};
      else if (ex2 <= 10'sd0)
         res = {sgn, 31'd0};
      else
         res = {sgn, ex2[7:0], rnd[22:0]};
   end

   generate
      if (STAGES == 0) begin : g_comb
         assign p_o = res;
      end else begin : g_pipe
         logic [31:0] pipe_q [STAGES];
         always_ff @(posedge clk) begin
            if (sclr) begin
               for (int i = 0; i < STAGES; i++)
                  pipe_q[i] <= '0;
            end else if (clk_en) begin
               pipe_q[0] <= res;
               for (int i = 1; i < STAGES; i++)
                  pipe_q[i] <= pipe_q[i-1];
            end
         end
         assign p_o = pipe_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/fp_to_cordic_stage_fp_to_q2_20.sv
// Combinational IEEE-754 single to signed fixed-point converter
// with saturation and an out-of-range / NaN / Inf flag.
module fp_to_q2_20
   import fp_to_cordic_stage_pkg::*;
#(
   parameter int IW = INT_W,
   parameter int FW = FRAC_W,
   localparam int CW = IW + FW
) (
   input  logic [31:0]   f_i,
   output logic [CW-1:0] q_o,
   output logic          err_o
);

   localparam logic signed [9:0] SAT_E = 10'(IW - 1);
   localparam logic signed [9:0] MIN_E = 10'(-FW);
   localparam logic signed [9:0] SH0   = 10'(23 - FW);

   logic              sgn;
   logic [7:0]        ex;
   logic [23:0]       man;
   logic signed [9:0] e;
   logic signed [9:0] sh;
   logic [CW-1:0]     mag;
   logic [CW-1:0]     pos_max;
   logic [CW-1:0]     neg_max;

   always_comb begin
      sgn     = f_i[31];
      ex      = f_i[30:23];
      man     = {1'b1, f_i[22:0]};
      e       = $signed({2'b00, ex}) - 10'sd127;
      sh      = SH0 - e;
      pos_max = {1'b0, {(CW-1){1'b1}}};
      neg_max = {1'b1, {(CW-1){1'b0}}};
      mag     = '0;
      q_o     = '0;
      err_o   = 1'b0;
      if (ex == 8'hFF) begin
         err_o = 1'b1;
         if (f_i[22:0] == 23'd0)
            q_o = sgn ? neg_max : pos_max;
      end else if (ex == 8'h00) begin
         q_o = '0;
      end else if (e >= SAT_E) begin
         err_o = 1'b1;
         q_o   = sgn ? neg_max : pos_max;
      end else if (e < MIN_E) begin
         q_o = '0;
      end else begin
         // value * 2^FW = man * 2^(e-23+FW); truncation toward zero
         if (!sh[9])
            mag = CW'(man >> sh[5:0]);
         else
            mag = CW'(man) << 6'(-sh);
         q_o = sgn ? ('0 - mag) : mag;
      end
   end

endmodule

// File: rtl/fp_to_cordic_stage.sv
// Converts two float operands to Q2.20 CORDIC angles and squares
// them; IDLE -> CONVERT -> MULTIPLY -> DONE, one job at a time.
module fp_to_cordic_stage
   import fp_to_cordic_stage_pkg::*;
#(
   parameter int FLOAT_DATA_WIDTH  = FLOAT_W,
   parameter int INTEGER_WIDTH     = INT_W,
   parameter int FRACTIONAL_WIDTH  = FRAC_W,
   parameter int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH,
   parameter int MULTIPLY_LATENCY  = MUL_LAT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic                         start,
   input  logic [FLOAT_DATA_WIDTH-1:0]  x_one,
   input  logic [FLOAT_DATA_WIDTH-1:0]  x_two,
   output logic [CORDIC_DATA_WIDTH-1:0] angle_one,
   output logic [CORDIC_DATA_WIDTH-1:0] angle_two,
   output logic [FLOAT_DATA_WIDTH-1:0]  one_squared,
   output logic [FLOAT_DATA_WIDTH-1:0]  two_squared,
   output logic                         done,
   output logic                         working,
   output logic                         range_err
);

   localparam int CNT_W = $clog2(MULTIPLY_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULTIPLY_LATENCY - 1);

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [FLOAT_DATA_WIDTH-1:0]  xa_q, xa_d, xb_q, xb_d;
   logic [CORDIC_DATA_WIDTH-1:0] ang1_q, ang1_d, ang2_q, ang2_d;
   logic [FLOAT_DATA_WIDTH-1:0]  sq1_q, sq1_d, sq2_q, sq2_d;
   logic                         done_q, done_d;
   logic                         work_q, work_d;
   logic                         err_q, err_d;
   logic                         mul_en;

   logic [CORDIC_DATA_WIDTH-1:0] q1, q2;
   logic                         e1, e2;
   logic [FLOAT_DATA_WIDTH-1:0]  p1, p2;

   fp_to_q2_20 #(
      .IW (INTEGER_WIDTH),
      .FW (FRACTIONAL_WIDTH)
   ) u_cvt_one (
      .f_i   (xa_q),
      .q_o   (q1),
      .err_o (e1)
   );

   fp_to_q2_20 #(
      .IW (INTEGER_WIDTH),
      .FW (FRACTIONAL_WIDTH)
   ) u_cvt_two (
      .f_i   (xb_q),
      .q_o   (q2),
      .err_o (e2)
   );

   // Square latch is the last pipeline register, so the cores hold one fewer
   fp_mul #(
      .STAGES (MULTIPLY_LATENCY - 1)
   ) u_mul_one (
      .clk    (clk),
      .sclr   (rst),
      .clk_en (mul_en & clk_en),
      .a_i    (xa_q),
      .b_i    (xa_q),
      .p_o    (p1)
   );

   fp_mul #(
      .STAGES (MULTIPLY_LATENCY - 1)
   ) u_mul_two (
      .clk    (clk),
      .sclr   (rst),
      .clk_en (mul_en & clk_en),
      .a_i    (xb_q),
      .b_i    (xb_q),
      .p_o    (p2)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xa_d    = xa_q;
      xb_d    = xb_q;
      ang1_d  = ang1_q;
      ang2_d  = ang2_q;
      sq1_d   = sq1_q;
      sq2_d   = sq2_q;
      done_d  = done_q;
      work_d  = work_q;
      err_d   = err_q;
      mul_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               xa_d    = x_one;
               xb_d    = x_two;
               work_d  = 1'b1;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            ang1_d  = q1;
            ang2_d  = q2;
            err_d   = e1 | e2;
            cnt_d   = '0;
            state_d = S_MULTIPLY;
         end
         S_MULTIPLY: begin
            mul_en = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               sq1_d   = p1;
               sq2_d   = p2;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b0;
            work_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         xa_q    <= '0;
         xb_q    <= '0;
         ang1_q  <= '0;
         ang2_q  <= '0;
         sq1_q   <= '0;
         sq2_q   <= '0;
         done_q  <= 1'b0;
         work_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         xa_q    <= xa_d;
         xb_q    <= xb_d;
         ang1_q  <= ang1_d;
         ang2_q  <= ang2_d;
         sq1_q   <= sq1_d;
         sq2_q   <= sq2_d;
         done_q  <= done_d;
         work_q  <= work_d;
         err_q   <= err_d;
      end
   end

   assign angle_one   = ang1_q;
   assign angle_two   = ang2_q;
   assign one_squared = sq1_q;
   assign two_squared = sq2_q;
   assign done        = done_q;
   assign working     = work_q;
   assign range_err   = err_q;

endmodule

// File: tb/tb_fp_to_cordic_stage.sv
// Directed bench for fp_to_cordic_stage: vector table plus reset,
// back-to-back start and clock-enable freeze sequences.
module tb_fp_to_cordic_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        start;
   logic [31:0] x_one, x_two;
   logic [21:0] angle_one, angle_two;
   logic [31:0] one_squared, two_squared;
   logic        done, working, range_err;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] x1;
      logic [31:0] x2;
      logic [21:0] a1;
      logic [21:0] a2;
      logic [31:0] s1;
      logic [31:0] s2;
      logic        err;
      logic        chk_sq;
   } vec_t;

   vec_t tv [8];

   fp_to_cordic_stage dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .start       (start),
      .x_one       (x_one),
      .x_two       (x_two),
      .angle_one   (angle_one),
      .angle_two   (angle_two),
      .one_squared (one_squared),
      .two_squared (two_squared),
      .done        (done),
      .working     (working),
      .range_err   (range_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                          output int lat);
      x_one = a;
      x_two = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic chk_out(input string nm, input vec_t v);
      chk({nm, " angle_one"}, 32'(angle_one), 32'(v.a1));
      chk({nm, " angle_two"}, 32'(angle_two), 32'(v.a2));
      chk({nm, " range_err"}, 32'(range_err), 32'(v.err));
      if (v.chk_sq) begin
         chk({nm, " one_sq"}, one_squared, v.s1);
         chk({nm, " two_sq"}, two_squared, v.s2);
      end
   endtask

   initial begin
      int   lat;
      logic seen;

      tv[0] = '{32'h3F000000, 32'hBF800000, 22'h080000, 22'h300000,
                32'h3E800000, 32'h3F800000, 1'b0, 1'b1};
      tv[1] = '{32'h40400000, 32'hC0400000, 22'h1FFFFF, 22'h200000,
                32'h41100000, 32'h41100000, 1'b1, 1'b1};
      tv[2] = '{32'h33D6BF95, 32'h00000001, 22'h000000, 22'h000000,
                32'h0, 32'h0, 1'b0, 1'b0};
      tv[3] = '{32'h7FC00000, 32'hFF800000, 22'h000000, 22'h200000,
                32'h7FC00000, 32'h7F800000, 1'b1, 1'b1};
      tv[4] = '{32'h3FC00000, 32'hBE800000, 22'h180000, 22'h3C0000,
                32'h40100000, 32'h3D800000, 1'b0, 1'b1};
      tv[5] = '{32'h40000000, 32'h35800000, 22'h1FFFFF, 22'h000001,
                32'h40800000, 32'h2B800000, 1'b1, 1'b1};
      tv[6] = '{32'h35000000, 32'h3FFFFFFF, 22'h000000, 22'h1FFFFF,
                32'h2A800000, 32'h407FFFFE, 1'b0, 1'b1};
      tv[7] = '{32'h80000000, 32'hBFFFFFFF, 22'h000000, 22'h200001,
                32'h00000000, 32'h407FFFFE, 1'b0, 1'b1};

      rst    = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      x_one  = '0;
      x_two  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst angle_one", 32'(angle_one), 32'd0);
      chk("rst angle_two", 32'(angle_two), 32'd0);
      chk("rst one_sq", one_squared, 32'd0);
      chk("rst two_sq", two_squared, 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst working", 32'(working), 32'd0);
      chk("rst range_err", 32'(range_err), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         run_job(tv[k].x1, tv[k].x2, lat);
         chk($sformatf("v%0d latency", k), 32'(lat), 32'd4);
         chk_out($sformatf("v%0d", k), tv[k]);
         chk($sformatf("v%0d working@done", k), 32'(working), 32'd1);
         @(posedge clk); #1;
         chk($sformatf("v%0d done pulse", k), 32'(done), 32'd0);
         chk($sformatf("v%0d working end", k), 32'(working), 32'd0);
      end

      // start held high: one accept every 6 cycles
      x_one = tv[0].x1;
      x_two = tv[0].x2;
      start = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold working c%0d", i), 32'(working),
             32'(i % 6 != 5));
         chk($sformatf("hold done c%0d", i), 32'(done),
             32'(i % 6 == 4));
      end
      start = 1'b0;
      chk_out("hold", tv[0]);

      // reset during MULTIPLY aborts the job
      x_one = tv[4].x1;
      x_two = tv[4].x2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort angle_one", 32'(angle_one), 32'd0);
      chk("abort angle_two", 32'(angle_two), 32'd0);
      chk("abort one_sq", one_squared, 32'd0);
      chk("abort two_sq", two_squared, 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort working", 32'(working), 32'd0);
      chk("abort range_err", 32'(range_err), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("abort no done", 32'(seen), 32'd0);
      run_job(tv[1].x1, tv[1].x2, lat);
      chk("post-abort latency", 32'(lat), 32'd4);
      chk_out("post-abort", tv[1]);
      @(posedge clk); #1;

      // clk_en low for 5 cycles during MULTIPLY
      x_one = tv[4].x1;
      x_two = tv[4].x2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clk_en = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("freeze no done", 32'(seen), 32'd0);
      chk("freeze working", 32'(working), 32'd1);
      clk_en = 1'b1;
      lat = 7;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("freeze latency", 32'(lat), 32'd9);
      chk_out("freeze", tv[4]);
      clk_en = 1'b0;
      @(posedge clk); #1;
      chk("stretch done 1", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("stretch done 2", 32'(done), 32'd1);
      clk_en = 1'b1;
      @(posedge clk); #1;
      chk("stretch done end", 32'(done), 32'd0);
      chk_out("stretch hold", tv[4]);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fp_to_cordic_stage.md
FP_TO_CORDIC_STAGE -- requirements
Module: fp_to_cordic_stage

Interface
REQ-001 SHALL have parameter FLOAT_DATA_WIDTH, default 32, IEEE-754 single word width.
REQ-002 SHALL have parameter INTEGER_WIDTH, default 2, fixed-point integer bits including sign.
REQ-003 SHALL have parameter FRACTIONAL_WIDTH, default 20, fixed-point fraction bits.
REQ-004 SHALL have parameter CORDIC_DATA_WIDTH, default INTEGER_WIDTH+FRACTIONAL_WIDTH (22), CORDIC operand width.
REQ-005 SHALL have parameter MULTIPLY_LATENCY, default 3, fp_mul pipeline depth in enabled cycles.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 clk_en  input  1  global enable; low freezes the FSM, counter and multipliers.
REQ-009 start  input  1  request; sampled only in IDLE with clk_en high.
REQ-010 x_one, x_two  input  32 each  float operands, captured on accept.
REQ-011 angle_one, angle_two  output  22 each  Q2.20 two's-complement CORDIC operands.
REQ-012 one_squared, two_squared  output  32 each  float x_one*x_one, x_two*x_two.
REQ-013 done  output  1  one-cycle pulse; outputs valid from this pulse until next accept.
REQ-014 working  output  1  high from accept until return to IDLE.
REQ-015 range_err  output  1  set when either operand saturated or was NaN/Inf; valid with done.

Function
REQ-016 SHALL implement states IDLE, CONVERT, MULTIPLY, DONE.
REQ-017 IDLE: on clk_en&start at edge N, latch x_one/x_two, working<=1, ->CONVERT; start otherwise ignored, including any start while working.
REQ-018 CONVERT (edge N+1): register angle_one/angle_two and range_err, clear multiply counter, ->MULTIPLY.
REQ-019 MULTIPLY: multiplier enable high; counter increments per enabled cycle; at edge N+4 (count reaches MULTIPLY_LATENCY) latch squares, done<=1, ->DONE.
REQ-020 DONE (edge N+5): done<=0, working<=0, ->IDLE; new start accepted no earlier than edge N+6.
REQ-021 clk_en low SHALL hold state, counter, outputs and multiplier pipeline; the pulse is extended one cycle per frozen cycle while done is high.
REQ-022 Conversion: e=exp-127, m={1,frac} (24 bits); magnitude = m shifted by (e-3), truncated toward zero.
REQ-023 e>=1 (|x|>=2): saturate to 0x1FFFFF for positive, 0x200000 for negative; range_err<=1.
REQ-024 e<-20, zero, or denormal: result 0, range_err unaffected.
REQ-025 NaN or Inf: result 0 (NaN) or saturated per sign (Inf); range_err<=1.
REQ-026 Negative in-range inputs: two's complement of magnitude, 22-bit wrap.
REQ-027 Squares SHALL come from fp_mul with both ports on the latched operand; no rounding beyond fp_mul.

Reset
REQ-028 rst SHALL force IDLE, all outputs to 0, counter to 0, and multiplier aclr; this overrides clk_en.
REQ-029 rst mid-operation SHALL abort with no done pulse; first accept possible the edge after rst deasserts.

Structure
REQ-030 Width parameters, state encodings (IDLE=00, CONVERT=01, MULTIPLY=10, DONE=11) and MULTIPLY_LATENCY SHALL live in the shared stage package used by stage_3.
REQ-031 One natural sub-module: fp_to_q2_20 (combinational float->fixed plus err flag), instantiated twice.
REQ-032 Two fp_mul core instances SHALL be used, with clk_en = multiplier enable & clk_en.

Verification
REQ-033 x_one=0x3F000000 (0.5), x_two=0xBF800000 (-1.0) -> angle_one=0x080000, angle_two=0x300000, squares 0x3E800000/0x3F800000, range_err=0, done at edge N+4.
REQ-034 x_one=0x40400000 (3.0), x_two=0xC0400000 -> 0x1FFFFF/0x200000, range_err=1, squares 0x41100000.
REQ-035 x_one=0x33D6BF95 (1e-7), x_two=0x00000001 -> both angles 0, range_err=0.
REQ-036 start held high continuously -> accepts every 6 cycles only; working never drops between back-to-back jobs except the IDLE cycle.
REQ-037 rst pulsed while in MULTIPLY -> no done, all outputs 0, next job correct.
REQ-038 clk_en low for 5 cycles during MULTIPLY -> done delayed exactly 5 cycles, values unchanged.
